if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_pkg.sv | 14 +
 rtl/if_static_predictor.sv | 23 ++
 rtl/if_stage.sv | 117 +++++++++++
 tb/tb_if_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared constants and fetch state type for the instruction fetch stage.
package if_pkg;

    localparam logic [5:0]  OP_BEQ           = 6'b000100;
    localparam logic [5:0]  OP_BNE           = 6'b000101;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        ST_WAIT  = 1'b0,
        ST_READY = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_static_predictor.sv
// Static backward-taken predictor: beq/bne with a negative displacement is
// predicted taken; target = pc + 4 + (sext(imm16) << 2).
module if_static_predictor
    import if_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        taken,
    output logic [31:0] target
);

    logic [5:0]         opcode;
    logic signed [31:0] offset;
    logic [9:0]         unused_reg_fields;

    assign opcode            = instr[31:26];
    assign unused_reg_fields = instr[25:16];
    assign offset            = {{14{instr[15]}}, instr[15:0], 2'b00};

    assign taken  = ((opcode == OP_BEQ) || (opcode == OP_BNE)) && (offset < 0);
    assign target = pc + 32'd4 + $unsigned(offset);

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with wait-state memory timing and IF/ID register.
// Optional static branch prediction enabled by defining IF_STATIC_PREDICT_EN.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        ifid_pred_taken
);

    localparam logic [3:0] CNT_LAST = 4'(MEM_WAIT - 1);

    fetch_state_t state, state_nx;
    logic [3:0]   cnt, cnt_nx;
    logic [31:0]  pc, pc_nx;
    logic [31:0]  instr_nx, pc4_nx;
    logic         valid_nx, pred_nx;
    logic [31:0]  pc_plus4, next_pc;
    logic         pred_taken;
    logic [1:0]   unused_redirect_lsb;

    assign imem_addr           = pc;
    assign pc_plus4            = pc + 32'd4;
    assign unused_redirect_lsb = redirect_pc[1:0];

`ifdef IF_STATIC_PREDICT_EN
    logic [31:0] pred_target;

    if_static_predictor u_pred (
        .instr  (imem_instr),
        .pc     (pc),
        .taken  (pred_taken),
        .target (pred_target)
    );

    assign next_pc = pred_taken ? pred_target : pc_plus4;
`else
    assign pred_taken = 1'b0;
    assign next_pc    = pc_plus4;
`endif

    // Redirect beats stall, stall beats everything else.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pc_nx    = pc;
        instr_nx = ifid_instr;
        pc4_nx   = ifid_pc4;
        valid_nx = ifid_valid;
        pred_nx  = ifid_pred_taken;

        if (redirect_valid) begin
            pc_nx    = {redirect_pc[31:2], 2'b00};
            cnt_nx   = 4'd0;
            state_nx = ST_WAIT;
            instr_nx = NOP_WORD;
            valid_nx = 1'b0;
            pred_nx  = 1'b0;
        end else if (!stall) begin
            case (state)
                ST_WAIT: begin
                    instr_nx = NOP_WORD;
                    valid_nx = 1'b0;
                    pred_nx  = 1'b0;
                    if (cnt == CNT_LAST) begin
                        state_nx = ST_READY;
                    end else begin
                        cnt_nx = cnt + 4'd1;
                    end
                end
                ST_READY: begin
                    instr_nx = imem_instr;
                    pc4_nx   = pc_plus4;
                    valid_nx = 1'b1;
                    pred_nx  = pred_taken;
                    pc_nx    = next_pc;
                    cnt_nx   = 4'd0;
                    state_nx = ST_WAIT;
                end
                default: state_nx = ST_WAIT;
            endcase
        end
    end

    // Fetch state and IF/ID register boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_WAIT;
            cnt             <= 4'd0;
            pc              <= RESET_PC;
            ifid_instr      <= NOP_WORD;
            ifid_pc4        <= 32'd0;
            ifid_valid      <= 1'b0;
            ifid_pred_taken <= 1'b0;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            pc              <= pc_nx;
            ifid_instr      <= instr_nx;
            ifid_pc4        <= pc4_nx;
            ifid_valid      <= valid_nx;
            ifid_pred_taken <= pred_nx;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized run
// against a cycle-age reference model, on MEM_WAIT=1 and MEM_WAIT=3 instances.
module tb_if_stage;

`ifdef IF_STATIC_PREDICT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    logic [31:0] addr1, instr1, ifid_instr1, ifid_pc41;
    logic        ifid_valid1, ifid_pred1;
    logic [31:0] addr3, instr3, ifid_instr3, ifid_pc43;
    logic        ifid_valid3, ifid_pred3;

    logic [31:0] mem [0:255];
    int          errors = 0;
    int          checks = 0;

    logic [31:0] m_pc [2], m_instr [2], m_pc4 [2];
    logic        m_valid [2], m_pred [2];
    int          m_age [2];

    logic [31:0] d_addr [2], d_instr [2], d_pc4 [2];
    logic        d_valid [2], d_pred [2];

    always #5 clk = ~clk;

    assign instr1 = mem[addr1[9:2]];
    assign instr3 = mem[addr3[9:2]];

    if_stage #(.RESET_PC(RESET_PC), .MEM_WAIT(1)) dut1 (
        .clk(clk), .reset(reset), .imem_addr(addr1), .imem_instr(instr1),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifid_instr(ifid_instr1), .ifid_pc4(ifid_pc41), .ifid_valid(ifid_valid1),
        .ifid_pred_taken(ifid_pred1)
    );

    if_stage #(.RESET_PC(RESET_PC), .MEM_WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .imem_addr(addr3), .imem_instr(instr3),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifid_instr(ifid_instr3), .ifid_pc4(ifid_pc43), .ifid_valid(ifid_valid3),
        .ifid_pred_taken(ifid_pred3)
    );

    always_comb begin
        d_addr[0] = addr1;        d_addr[1] = addr3;
        d_instr[0] = ifid_instr1; d_instr[1] = ifid_instr3;
        d_pc4[0] = ifid_pc41;     d_pc4[1] = ifid_pc43;
        d_valid[0] = ifid_valid1; d_valid[1] = ifid_valid3;
        d_pred[0] = ifid_pred1;   d_pred[1] = ifid_pred3;
    end

    function automatic int mwait(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Reference: an address must have been presented for MEM_WAIT unstalled
    // cycles before the word at it can be captured.
    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = RESET_PC; m_age[k] = 0; m_instr[k] = 32'd0;
            m_pc4[k] = 32'd0; m_valid[k] = 1'b0; m_pred[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        logic [31:0] w, tgt;
        bit          tk;
        w   = mem[m_pc[k][9:2]];
        tk  = PRED && ((w[31:26] == 6'd4) || (w[31:26] == 6'd5)) && w[15];
        tgt = m_pc[k] + 32'd4 + {{14{w[15]}}, w[15:0], 2'b00};
        if (redirect_valid) begin
            m_pc[k] = redirect_pc & 32'hFFFF_FFFC;
            m_age[k] = 0; m_valid[k] = 1'b0; m_instr[k] = 32'd0; m_pred[k] = 1'b0;
        end else if (!stall) begin
            if (m_age[k] >= mwait(k)) begin
                m_instr[k] = w; m_pc4[k] = m_pc[k] + 32'd4; m_valid[k] = 1'b1;
                m_pred[k] = tk; m_pc[k] = tk ? tgt : m_pc[k] + 32'd4; m_age[k] = 0;
            end else begin
                m_age[k]++; m_valid[k] = 1'b0; m_instr[k] = 32'd0; m_pred[k] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic apply_reset();
        #2;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic mem_default();
        for (int i = 0; i < 256; i++) mem[i] = {6'b001000, 26'(i * 7 + 3)};
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (d_addr[k] !== RESET_PC) begin errors++; $display("FAIL reset_addr[%0d]: got %h expected %h", k, d_addr[k], RESET_PC); end
            checks++; if (d_instr[k] !== 32'd0) begin errors++; $display("FAIL reset_instr[%0d]: got %h expected 0", k, d_instr[k]); end
            checks++; if (d_pc4[k] !== 32'd0) begin errors++; $display("FAIL reset_pc4[%0d]: got %h expected 0", k, d_pc4[k]); end
            checks++; if (d_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b expected 0", k, d_valid[k]); end
            checks++; if (d_pred[k] !== 1'b0) begin errors++; $display("FAIL reset_pred[%0d]: got %b expected 0", k, d_pred[k]); end
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_fetch();
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0003;
        apply_reset();
        tick();
        checks++; if (ifid_valid1 !== 1'b0) begin errors++; $display("FAIL fetch_e1_valid: got %b expected 0", ifid_valid1); end
        tick();
        checks++; if (ifid_instr1 !== 32'h2008_0005) begin errors++; $display("FAIL fetch_e2_instr: got %h expected 20080005", ifid_instr1); end
        checks++; if (ifid_pc41 !== 32'd4) begin errors++; $display("FAIL fetch_e2_pc4: got %h expected 4", ifid_pc41); end
        checks++; if (ifid_valid1 !== 1'b1) begin errors++; $display("FAIL fetch_e2_valid: got %b expected 1", ifid_valid1); end
        checks++; if (addr1 !== 32'd4) begin errors++; $display("FAIL fetch_e2_addr: got %h expected 4", addr1); end
        tick();
        checks++; if (ifid_valid1 !== 1'b0) begin errors++; $display("FAIL fetch_e3_valid: got %b expected 0", ifid_valid1); end
        checks++; if (ifid_instr1 !== 32'd0) begin errors++; $display("FAIL fetch_e3_instr: got %h expected 0", ifid_instr1); end
        tick();
        checks++; if (ifid_instr1 !== 32'h2009_0003) begin errors++; $display("FAIL fetch_e4_instr: got %h expected 20090003", ifid_instr1); end
        checks++; if (ifid_pc41 !== 32'd8) begin errors++; $display("FAIL fetch_e4_pc4: got %h expected 8", ifid_pc41); end
        checks++; if (ifid_valid1 !== 1'b1) begin errors++; $display("FAIL fetch_e4_valid: got %b expected 1", ifid_valid1); end
    endtask

    task automatic test_stall();
        apply_reset();
        tick(); tick(); tick();
        checks++; if (addr1 !== 32'd4) begin errors++; $display("FAIL stall_pre_addr: got %h expected 4", addr1); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (addr1 !== 32'd4) begin errors++; $display("FAIL stall_addr c%0d: got %h expected 4", i, addr1); end
            checks++; if (ifid_valid1 !== 1'b0) begin errors++; $display("FAIL stall_valid c%0d: got %b expected 0", i, ifid_valid1); end
            checks++; if (ifid_instr1 !== 32'd0) begin errors++; $display("FAIL stall_instr c%0d: got %h expected 0", i, ifid_instr1); end
        end
        stall = 1'b0;
        tick();
        checks++; if (ifid_instr1 !== 32'h2009_0003) begin errors++; $display("FAIL stall_release_instr: got %h expected 20090003", ifid_instr1); end
        checks++; if (ifid_pc41 !== 32'd8) begin errors++; $display("FAIL stall_release_pc4: got %h expected 8", ifid_pc41); end
        checks++; if (ifid_valid1 !== 1'b1) begin errors++; $display("FAIL stall_release_valid: got %b expected 1", ifid_valid1); end
    endtask

    task automatic test_redirect();
        mem[16] = 32'h2000_4040;
        apply_reset();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0043; stall = 1'b1;
        tick();
        checks++; if (addr1 !== 32'h40) begin errors++; $display("FAIL redirect_addr1: got %h expected 40", addr1); end
        checks++; if (addr3 !== 32'h40) begin errors++; $display("FAIL redirect_addr3: got %h expected 40", addr3); end
        checks++; if (ifid_valid1 !== 1'b0) begin errors++; $display("FAIL redirect_valid: got %b expected 0", ifid_valid1); end
        checks++; if (ifid_instr1 !== 32'd0) begin errors++; $display("FAIL redirect_instr: got %h expected 0", ifid_instr1); end
        redirect_valid = 1'b0; stall = 1'b0;
        tick();
        checks++; if (ifid_valid1 !== 1'b0) begin errors++; $display("FAIL redirect_wait_valid: got %b expected 0", ifid_valid1); end
        tick();
        checks++; if (ifid_instr1 !== 32'h2000_4040) begin errors++; $display("FAIL redirect_cap_instr: got %h expected 20004040", ifid_instr1); end
        checks++; if (ifid_pc41 !== 32'h44) begin errors++; $display("FAIL redirect_cap_pc4: got %h expected 44", ifid_pc41); end
    endtask

    task automatic test_wrap();
        mem[255] = 32'h2000_ABCD;
        apply_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        checks++; if (addr1 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr_pre: got %h expected fffffffc", addr1); end
        tick(); tick();
        checks++; if (ifid_pc41 !== 32'd0) begin errors++; $display("FAIL wrap_pc4: got %h expected 0", ifid_pc41); end
        checks++; if (addr1 !== 32'd0) begin errors++; $display("FAIL wrap_addr: got %h expected 0", addr1); end
        checks++; if (ifid_instr1 !== 32'h2000_ABCD) begin errors++; $display("FAIL wrap_instr: got %h expected 2000abcd", ifid_instr1); end
    endtask

    task automatic test_predict();
        logic [31:0] exp_addr;
        exp_addr = PRED ? 32'h0000_000C : 32'h0000_0014;
        mem[4] = 32'h1000_FFFE;
        apply_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        checks++; if (ifid_instr1 !== 32'h1000_FFFE) begin errors++; $display("FAIL pred_instr: got %h expected 1000fffe", ifid_instr1); end
        checks++; if (ifid_pred1 !== PRED) begin errors++; $display("FAIL pred_taken: got %b expected %b", ifid_pred1, PRED); end
        checks++; if (addr1 !== exp_addr) begin errors++; $display("FAIL pred_next_addr: got %h expected %h", addr1, exp_addr); end
        checks++; if (ifid_pc41 !== 32'h14) begin errors++; $display("FAIL pred_pc4: got %h expected 14", ifid_pc41); end
        mem[4] = 32'h2000_0004;
    endtask

    task automatic test_reset_mid_wait();
        mem[0]  = 32'h2008_0005;
        mem[32] = 32'h2000_0080;
        apply_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        tick(); tick(); tick(); tick();
        checks++; if (ifid_instr3 !== 32'h2000_0080) begin errors++; $display("FAIL rmw_pre_instr: got %h expected 20000080", ifid_instr3); end
        stall = 1'b1;
        tick();
        #1;
        reset = 1'b1;
        #1;
        checks++; if (addr3 !== RESET_PC) begin errors++; $display("FAIL rmw_async_addr: got %h expected %h", addr3, RESET_PC); end
        checks++; if (ifid_instr3 !== 32'd0) begin errors++; $display("FAIL rmw_async_instr: got %h expected 0", ifid_instr3); end
        checks++; if (ifid_pc43 !== 32'd0) begin errors++; $display("FAIL rmw_async_pc4: got %h expected 0", ifid_pc43); end
        checks++; if (ifid_valid3 !== 1'b0) begin errors++; $display("FAIL rmw_async_valid: got %b expected 0", ifid_valid3); end
        stall = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++; if (ifid_valid3 !== 1'b0) begin errors++; $display("FAIL rmw_edge%0d_valid: got %b expected 0", e, ifid_valid3); end
        end
        tick();
        checks++; if (ifid_valid3 !== 1'b1) begin errors++; $display("FAIL rmw_edge4_valid: got %b expected 1", ifid_valid3); end
        checks++; if (ifid_instr3 !== 32'h2008_0005) begin errors++; $display("FAIL rmw_edge4_instr: got %h expected 20080005", ifid_instr3); end
        checks++; if (ifid_pc43 !== 32'd4) begin errors++; $display("FAIL rmw_edge4_pc4: got %h expected 4", ifid_pc43); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if ($urandom_range(0, 2) == 0) w[31:26] = 6'($urandom_range(4, 5));
            mem[i] = w;
        end
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = m_pc[c % 2] | 32'($urandom_range(0, 3));
            else redirect_pc = 32'($urandom_range(0, 1023));
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++; if (d_addr[k] !== m_pc[k]) begin errors++; $display("FAIL rnd_addr[%0d] c%0d: got %h expected %h", k, c, d_addr[k], m_pc[k]); end
                checks++; if (d_instr[k] !== m_instr[k]) begin errors++; $display("FAIL rnd_instr[%0d] c%0d: got %h expected %h", k, c, d_instr[k], m_instr[k]); end
                checks++; if (d_pc4[k] !== m_pc4[k]) begin errors++; $display("FAIL rnd_pc4[%0d] c%0d: got %h expected %h", k, c, d_pc4[k], m_pc4[k]); end
                checks++; if (d_valid[k] !== m_valid[k]) begin errors++; $display("FAIL rnd_valid[%0d] c%0d: got %b expected %b", k, c, d_valid[k], m_valid[k]); end
                checks++; if (d_pred[k] !== m_pred[k]) begin errors++; $display("FAIL rnd_pred[%0d] c%0d: got %b expected %b", k, c, d_pred[k], m_pred[k]); end
            end
        end
        stall = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_default();
        model_reset();
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect();
        test_wrap();
        test_predict();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
